pipelined_addsub: RTL and testbench

- Parametrised pipelined ripple-carry adder/subtractor for the floating-point multiplier datapath: mantissa adds, exponent bias add/subtract, normalisation increments.
- Splits a WIDTH-bit add into STAGES registered ripple segments, so long carry chains meet timing.
- Accepts one operation per cycle under a valid/ready handshake with full backpressure.
- Adds over the plain adder: subtract mode, carry-in, signed-overflow flag and a zero flag.

---
 rtl/fpm_params_pkg.sv | 20 ++
 rtl/addsub_segment.sv | 34 +++
 rtl/pipelined_addsub.sv | 137 +++++++++++++
 tb/tb_pipelined_addsub.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_params_pkg.sv
// Shared constants and helper functions for the floating-point multiplier datapath.
//   MANT_W / EXP_W : default operand widths for mantissa and exponent arithmetic.
//   seg_width()    : bits per ripple segment for a given width and requested depth.
//   eff_stages()   : depth actually built once empty trailing segments are dropped.
package fpm_params_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;

  // Bits per ripple segment: ceil(w / s).
  function automatic int unsigned seg_width(input int unsigned w, input int unsigned s);
    return (w + s - 1) / s;
  endfunction

  // Number of non-empty segments, which is also the pipeline latency.
  function automatic int unsigned eff_stages(input int unsigned w, input int unsigned s);
    return (w + seg_width(w, s) - 1) / seg_width(w, s);
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational ripple-carry segment used by each stage of pipelined_addsub.
//   a_i, b_i   : W-bit operand slices (b_i already inverted for subtract).
//   cin_i      : carry into the segment LSB.
//   sum_o      : W-bit sum slice.
//   cout_o     : carry out of the segment MSB.
//   c_msb_in_o : carry into the segment MSB (overflow detection in the top segment).
module addsub_segment #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_in_o
);

  logic [W:0] carry;

  // Bit-serial ripple: carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < int'(W); i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o     = carry[W];
  assign c_msb_in_o = carry[W-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// A WIDTH-bit add is cut into ceil(WIDTH/SEG) registered ripple segments; each
// stage register holds one word whose low bits are finished result and whose
// high bits are still operand A, plus the (inverted) B word and the carry.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset.
//   i_valid / o_ready   : input handshake (o_ready = !o_valid | i_ready).
//   i_a, i_b            : operands.
//   i_sub               : 1 = A-B (as A+~B+1, i_cin ignored), 0 = A+B+i_cin.
//   i_cin               : carry-in for add mode.
//   o_valid / i_ready   : output handshake.
//   o_result            : sum/difference modulo 2^WIDTH.
//   o_carry             : MSB carry-out (subtract: 1 = no borrow).
//   o_ovf               : signed two's-complement overflow.
//   o_zero              : o_result == 0, decoded from the output register.
module pipelined_addsub
  import fpm_params_pkg::*;
#(
  parameter int unsigned WIDTH  = MANT_W,
  parameter int unsigned STAGES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);
  localparam int unsigned NST = eff_stages(WIDTH, STAGES);

  // Stage registers: index k is the output of stage k.
  logic [NST-1:0]   v_q, v_d;
  logic [WIDTH-1:0] rw_q [NST];
  logic [WIDTH-1:0] rw_d [NST];
  logic [WIDTH-1:0] b_q  [NST];
  logic [WIDTH-1:0] b_d  [NST];
  logic [NST-1:0]   c_q, c_d;
  logic             ovf_q, ovf_d;
  logic [NST-1:0]   c_msb;
  logic             adv_c;

  // Whole pipeline moves together; a stalled pipe keeps its bubbles.
  assign adv_c = !v_q[NST-1] | i_ready;

  // One ripple segment per stage.
  for (genvar k = 0; k < int'(NST); k++) begin : g_st
    localparam int unsigned LO = k * SEG;
    localparam int unsigned HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
    localparam int unsigned SW = HI - LO;
    localparam logic [WIDTH-1:0] SEG_MASK = ((WIDTH'(1) << SW) - WIDTH'(1)) << LO;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic [SW-1:0]    sum;
    logic             cout;

    if (k == 0) begin : g_in
      // Subtract folds into an add of ~B with a forced carry-in.
      assign a_in = i_a;
      assign b_in = i_sub ? ~i_b : i_b;
      assign c_in = i_sub | i_cin;
    end else begin : g_pipe
      assign a_in = rw_q[k-1];
      assign b_in = b_q[k-1];
      assign c_in = c_q[k-1];
    end

    addsub_segment #(
      .W (SW)
    ) u_seg (
      .a_i        (a_in[HI-1:LO]),
      .b_i        (b_in[HI-1:LO]),
      .cin_i      (c_in),
      .sum_o      (sum),
      .cout_o     (cout),
      .c_msb_in_o (c_msb[k])
    );

    // Splice this segment's sum into the word; lower result and upper A pass through.
    assign rw_d[k] = (a_in & ~SEG_MASK) | (WIDTH'(sum) << LO);
    assign b_d[k]  = b_in;
    assign c_d[k]  = cout;
  end

  // Valid shift: stage 0 takes i_valid, others take their predecessor.
  always_comb begin
    v_d = NST'({v_q, i_valid});
  end

  // Overflow is resolved in the last stage only.
  always_comb begin
    ovf_d = c_msb[NST-1] ^ c_d[NST-1];
  end

  // Pipeline registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < int'(NST); k++) begin
        rw_q[k] <= '0;
        b_q[k]  <= '0;
      end
    end else if (adv_c) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < int'(NST); k++) begin
        rw_q[k] <= rw_d[k];
        b_q[k]  <= b_d[k];
      end
    end
  end

  // Lower-segment MSB carries and the final B copy have no consumer.
  logic unused_taps;
  assign unused_taps = (^c_msb) ^ (^b_q[NST-1]);

  assign o_ready  = adv_c;
  assign o_valid  = v_q[NST-1];
  assign o_result = rw_q[NST-1];
  assign o_carry  = c_q[NST-1];
  assign o_ovf    = ovf_q;
  assign o_zero   = (rw_q[NST-1] == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: four instances (8/2, 24/3, 7/3, 8/1) share one
// stimulus stream; each keeps its own scoreboard against an arithmetic model.
module tb_pipelined_addsub;

  localparam int NDUT = 4;
  localparam int unsigned CW [NDUT] = '{8, 24, 7, 8};
  localparam int unsigned CS [NDUT] = '{2, 3, 3, 1};

  typedef struct packed {
    logic [23:0] res;
    logic        carry;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic        in_sub;
  logic        in_cin;
  logic        rdy;
  logic        lat_chk;

  logic [NDUT-1:0] ovld, ordy, ocar, oovf, ozer;
  logic [23:0]     ores [NDUT];
  int              pend [NDUT];

  int n_cmp;
  int n_bad;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference: exact integer sum, then wrap and range tests.
  function automatic exp_t ref_op(input int unsigned w, input logic [23:0] a,
                                  input logic [23:0] b, input logic sub, input logic cin);
    longint unsigned m, ua, ub, full, c0;
    longint          sa, sb, s, half;
    exp_t            e;
    m    = 64'd1 << w;
    half = longint'(m / 2);
    ua   = 64'(a) % m;
    ub   = 64'(b) % m;
    if (sub) ub = (m - 64'd1) - ub;
    c0   = (sub || cin) ? 64'd1 : 64'd0;
    full = ua + ub + c0;
    e.res   = 24'(full % m);
    e.carry = (full >= m);
    sa = (longint'(ua) >= half) ? longint'(ua) - longint'(m) : longint'(ua);
    sb = (longint'(ub) >= half) ? longint'(ub) - longint'(m) : longint'(ub);
    s  = sa + sb + longint'(c0);
    e.ovf  = (s >= half) || (s < -half);
    e.zero = (e.res == 24'd0);
    return e;
  endfunction

  function automatic int lat_of(input int unsigned w, input int unsigned s);
    int unsigned seg;
    seg = (w + s - 1) / s;
    return int'((w + seg - 1) / seg);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned W   = CW[g];
    localparam int unsigned S   = CS[g];
    localparam int          LAT = lat_of(W, S);

    logic [W-1:0] res;

    pipelined_addsub #(
      .WIDTH  (W),
      .STAGES (S)
    ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_valid  (in_valid),
      .o_ready  (ordy[g]),
      .i_a      (in_a[W-1:0]),
      .i_b      (in_b[W-1:0]),
      .i_sub    (in_sub),
      .i_cin    (in_cin),
      .o_valid  (ovld[g]),
      .i_ready  (rdy),
      .o_result (res),
      .o_carry  (ocar[g]),
      .o_ovf    (oovf[g]),
      .o_zero   (ozer[g])
    );

    assign ores[g] = 24'(res);

    // Scoreboard / handshake monitor, sampled on the falling edge.
    initial begin
      exp_t        q [$];
      int          tq [$];
      exp_t        e;
      int          t;
      logic        held;
      logic [27:0] hold_v;
      held = 1'b0;
      hold_v = '0;
      pend[g] = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          tq.delete();
          held = 1'b0;
          chk($sformatf("d%0d.rst_valid", g), 64'(ovld[g]), 64'(0));
          chk($sformatf("d%0d.rst_ready", g), 64'(ordy[g]), 64'(1));
        end else begin
          chk($sformatf("d%0d.ready", g), 64'(ordy[g]), 64'(!ovld[g] || rdy));
          if (held)
            chk($sformatf("d%0d.stall_hold", g),
                64'({ovld[g], ores[g], ocar[g], oovf[g], ozer[g]}), 64'(hold_v));
          held   = ovld[g] && !rdy;
          hold_v = {ovld[g], ores[g], ocar[g], oovf[g], ozer[g]};
          if (ovld[g] && rdy) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL d%0d.spurious: got o_valid with result %0h, expected no output",
                       g, ores[g]);
            end else begin
              e = q.pop_front();
              t = tq.pop_front();
              chk($sformatf("d%0d.result", g), 64'(ores[g]), 64'(e.res));
              chk($sformatf("d%0d.carry", g), 64'(ocar[g]), 64'(e.carry));
              chk($sformatf("d%0d.ovf", g), 64'(oovf[g]), 64'(e.ovf));
              chk($sformatf("d%0d.zero", g), 64'(ozer[g]), 64'(e.zero));
              if (lat_chk)
                chk($sformatf("d%0d.latency", g), 64'(cyc - t), 64'(LAT));
            end
          end
          if (in_valid && ordy[g]) begin
            q.push_back(ref_op(W, in_a, in_b, in_sub, in_cin));
            tq.push_back(cyc);
          end
        end
        pend[g] = q.size();
      end
    end
  end

  // One directed op on the 8-bit/2-stage instance with exact-latency checks.
  task automatic run_vec(input vec_t v, input string nm);
    @(posedge clk); #1;
    in_a     = 24'(v.a);
    in_b     = 24'(v.b);
    in_sub   = v.sub;
    in_cin   = v.cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, ".early"}, 64'(ovld[0]), 64'(0));
    @(posedge clk); #1;
    chk({nm, ".valid"}, 64'(ovld[0]), 64'(1));
    chk({nm, ".res"},   64'(ores[0]), 64'(v.res));
    chk({nm, ".carry"}, 64'(ocar[0]), 64'(v.carry));
    chk({nm, ".ovf"},   64'(oovf[0]), 64'(v.ovf));
    chk({nm, ".zero"},  64'(ozer[0]), 64'(v.zero));
  endtask

  task automatic drain_and_check(input string nm);
    in_valid = 1'b0;
    rdy      = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("%s.pending%0d", nm, g), 64'(pend[g]), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [12];
    int   lats [NDUT];
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_sub   = 1'b0;
    in_cin   = 1'b0;
    rdy      = 1'b1;
    lat_chk  = 1'b0;
    for (int g = 0; g < NDUT; g++) lats[g] = lat_of(CW[g], CS[g]);

    //           a      b      sub  cin   res    c    v    z
    tbl[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{8'h12, 8'h12, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{8'h0F, 8'hF0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("reset.valid%0d", g), 64'(ovld[g]), 64'(0));
      chk($sformatf("reset.ready%0d", g), 64'(ordy[g]), 64'(1));
      chk($sformatf("reset.res%0d", g),   64'(ores[g]), 64'(0));
      chk($sformatf("reset.carry%0d", g), 64'(ocar[g]), 64'(0));
      chk($sformatf("reset.ovf%0d", g),   64'(oovf[g]), 64'(0));
      chk($sformatf("reset.zero%0d", g),  64'(ozer[g]), 64'(1));
    end
    @(negedge clk); #2;
    rst_n = 1'b1;

    // Directed table.
    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back streaming with i_ready held high.
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NDUT; g++)
        if (i >= lats[g]) chk($sformatf("stream.valid%0d", g), 64'(ovld[g]), 64'(1));
      in_a     = 24'($urandom());
      in_b     = 24'($urandom());
      in_sub   = 1'($urandom_range(0, 1));
      in_cin   = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    drain_and_check("stream");

    // Random backpressure (30% ready) and random input validity.
    lat_chk = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      rdy      = ($urandom_range(0, 9) < 3);
      in_valid = 1'($urandom_range(0, 1));
      in_a     = 24'($urandom());
      in_b     = 24'($urandom());
      in_sub   = 1'($urandom_range(0, 1));
      in_cin   = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    drain_and_check("bp");

    // Reset with two ops in flight.
    @(posedge clk); #1;
    in_a = 24'h00_0011; in_b = 24'h00_0022; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 24'h00_0033; in_b = 24'h00_0004; in_sub = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight.valid0", 64'(ovld[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      chk($sformatf("midrst.valid%0d", g), 64'(ovld[g]), 64'(0));
      chk($sformatf("midrst.ready%0d", g), 64'(ordy[g]), 64'(1));
      chk($sformatf("midrst.res%0d", g),   64'(ores[g]), 64'(0));
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    lat_chk = 1'b1;
    repeat (6) @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++)
      chk($sformatf("post_rst.stale%0d", g), 64'(ovld[g]), 64'(0));
    run_vec(tbl[2], "post_rst");
    drain_and_check("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
